// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel motion engine.
// LFSR seed/taps are only used when BARREL_LADDER_DROP_EN is defined.
package barrel_pkg;

    localparam int POS_W = 11;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_FALL = 2'd2,
        ST_DONE = 2'd3
    } BARREL_STATE_T;

endpackage

// File: rtl/barrel_move_step_tick.sv
// Movement-tick prescaler: counts 0..STEP_TIME-1 while run is high and
// flags tick on the last count. clr forces the count back to zero.
module step_tick #(
    parameter int STEP_TIME = 650_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (STEP_TIME > 1) ? $clog2(STEP_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TIME - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise count and wrap on the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/barrel_move.sv
// Per-barrel motion engine: rolls a barrel along zig-zag platforms, drops
// it between levels and pulses done when it leaves the last platform.
// Optional macro BARREL_LADDER_DROP_EN adds an LFSR-driven early drop at
// the LADDER_X column.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | parked at spawn, waiting for enable & start_game
// ROLL    | moving one pixel per tick along a platform
// FALL    | dropping FALL_STEP pixels per tick to next level
// DONE    | one-cycle done pulse, then back to IDLE
module barrel_move
    import barrel_pkg::*;
#(
    parameter int STEP_TIME = 650_000,
    parameter int START_X   = 100,
    parameter int START_Y   = 150,
    parameter int X_MIN     = 100,
    parameter int X_MAX     = 700,
    parameter int LEVELS    = 5,
    parameter int SPACING   = 96,
    parameter int FALL_STEP = 2,
    parameter int LADDER_X  = 400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_game,
    input  logic             enable,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             active,
    output logic             done
);

    localparam int FC_W = $clog2(SPACING + 1);
    localparam int LV_W = $clog2(LEVELS + 1);

    localparam logic [POS_W-1:0] X_START  = POS_W'(START_X);
    localparam logic [POS_W-1:0] Y_START  = POS_W'(START_Y);
    localparam logic [POS_W-1:0] X_LO     = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_HI     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_STEP   = POS_W'(FALL_STEP);
    localparam logic [FC_W-1:0]  FC_STEP  = FC_W'(FALL_STEP);
    localparam logic [FC_W-1:0]  FC_DROP  = FC_W'(SPACING);
    localparam logic [LV_W-1:0]  LV_LAST  = LV_W'(LEVELS - 1);

    BARREL_STATE_T    state_q, state_d;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic             dir_q, dir_d;        // 1 = moving right
    logic [FC_W-1:0]  fall_cnt_q, fall_cnt_d;
    logic [LV_W-1:0]  level_q, level_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic             tick;
    logic             moving;
    logic             abort;
    logic [POS_W-1:0] x_next;
    logic [POS_W-1:0] edge_x;
    logic             ladder_hit;

    assign moving = (state_q == ST_ROLL) || (state_q == ST_FALL);
    assign abort  = !start_game || !enable;
    assign x_next = dir_q ? xpos_q + 1'b1 : xpos_q - 1'b1;
    assign edge_x = dir_q ? X_HI : X_LO;

    // Prescaler restarts from zero on every state change.
    step_tick #(
        .STEP_TIME (STEP_TIME)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .run  (moving),
        .tick (tick)
    );

`ifdef BARREL_LADDER_DROP_EN
    localparam logic [POS_W-1:0] X_LADDER = POS_W'(LADDER_X);

    logic [7:0] lfsr_q, lfsr_d;

    // LFSR steps once per movement tick, independent of state changes.
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // LFSR register, reseeded only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ladder_hit = (x_next == X_LADDER) && lfsr_q[0] && (level_q < LV_LAST);
`else
    assign ladder_hit = 1'b0;
`endif

    // Motion FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        dir_d      = dir_q;
        fall_cnt_d = fall_cnt_q;
        level_d    = level_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && start_game) begin
                    state_d = ST_ROLL;
                end
            end
            ST_ROLL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    xpos_d = x_next;
                    if (x_next == edge_x) begin
                        state_d = (level_q == LV_LAST) ? ST_DONE : ST_FALL;
                    end else if (ladder_hit) begin
                        state_d = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    ypos_d = ypos_q + Y_STEP;
                    if (fall_cnt_q + FC_STEP == FC_DROP) begin
                        fall_cnt_d = '0;
                        dir_d      = !dir_q;
                        level_d    = level_q + 1'b1;
                        state_d    = ST_ROLL;
                    end else begin
                        fall_cnt_d = fall_cnt_q + FC_STEP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any way into IDLE (abort, finish) parks the barrel at spawn.
        if (state_d == ST_IDLE) begin
            xpos_d     = X_START;
            ypos_d     = Y_START;
            dir_d      = 1'b1;
            fall_cnt_d = '0;
            level_d    = '0;
        end
    end

    assign active_d = (state_d == ST_ROLL) || (state_d == ST_FALL);
    assign done_d   = (state_d == ST_DONE);

    // State, position and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            xpos_q     <= X_START;
            ypos_q     <= Y_START;
            dir_q      <= 1'b1;
            fall_cnt_q <= '0;
            level_q    <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            dir_q      <= dir_d;
            fall_cnt_q <= fall_cnt_d;
            level_q    <= level_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign active = active_q;
    assign done   = done_q;

endmodule
